// File: rtl/mem_bus_master.sv
// CPU-side initiator for the synchronous 8-bit memory bus: one load/store at a time, strobe sequencing, read capture.
// Optional build macro MEM_BUS_ROM_PROTECT_EN rejects stores to the ROM region (addresses 0-127).
module mem_bus_master #(
    parameter int unsigned READ_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] mem_address,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT);

    state_e     state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       write_q, write_d;
    logic       reject_q, reject_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       mem_write_q, mem_write_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_err_q, rsp_err_d;
    logic       store_rejected;

`ifdef MEM_BUS_ROM_PROTECT_EN
    assign store_rejected = req_write && !req_addr[7];
`else
    assign store_rejected = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        write_d     = write_q;
        reject_d    = reject_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    write_d     = req_write;
                    reject_d    = store_rejected;
                    // Strobe is registered so it is high for exactly the ISSUE cycle.
                    mem_write_d = req_write && !store_rejected;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = reject_q;
                    state_d     = DONE;
                end else if (WAIT_INIT != 3'd0) begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = WAIT;
                end else begin
                    state_d = CAPTURE;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q <= 3'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d     = mem_rdata;
                rsp_valid_d = 1'b1;
                rsp_err_d   = reject_q;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 3'd0;
            write_q     <= 1'b0;
            reject_q    <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            write_q     <= write_d;
            reject_q    <= reject_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_address = addr_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: instance 0 uses READ_WAIT=0, instance 1 uses READ_WAIT=3,
// each attached to a one-cycle-latency synchronous memory model.
module tb_mem_bus_master;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

`ifdef MEM_BUS_ROM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_write [2];
    logic [7:0] req_addr [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       rsp_err [2];
    logic [7:0] mem_address [2];
    logic       mem_write [2];
    logic [7:0] mem_wdata [2];

    logic [7:0] ref_mem [2][256];
    logic [7:0] last_rdata [2];
    exp_t       sb [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    function automatic int rw_of(input int d);
        return d * 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [256];
        logic [7:0] rdata;

        mem_bus_master #(.READ_WAIT(g * 3)) dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_rdata  (rsp_rdata[g]),
            .rsp_err    (rsp_err[g]),
            .mem_address(mem_address[g]),
            .mem_write  (mem_write[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (rdata)
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end

        always @(posedge clk) begin
            if (mem_write[g]) mem[mem_address[g]] <= mem_wdata[g];
            rdata <= mem[mem_address[g]];
        end
    end

    // Presents a request and pushes the response it must produce.
    task automatic drive_req(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.err = wr && PROT && (addr < 8'd128);
        if (wr) begin
            if (!e.err) ref_mem[d][addr] = wdata;
            e.rdata = last_rdata[d];
        end else begin
            e.rdata = ref_mem[d][addr];
            last_rdata[d] = e.rdata;
        end
        sb.push_back(e);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
    endtask

    task automatic run_req(input int d, input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input string tag);
        int   lat, pulses, rsp_i, wr_cnt, wr_i, hold_bad, ready_bad, exp_wr;
        bit   rej, exp_ready;
        exp_t want;
        rej    = wr && PROT && (addr < 8'd128);
        lat    = wr ? 1 : 2 + rw_of(d);
        exp_wr = (wr && !rej) ? 1 : 0;
        n_cmp++;
        if (req_ready[d] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s/ready_idle: got %b want 1", tag, req_ready[d]);
        end
        drive_req(d, wr, addr, wdata);
        pulses = 0; rsp_i = -1; wr_cnt = 0; wr_i = -1; hold_bad = 0; ready_bad = 0;
        for (int i = 0; i < lat + 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Scramble the inputs so any use of live request signals after acceptance shows up.
                req_valid[d] = 1'b0;
                req_write[d] = ~wr;
                req_addr[d]  = ~addr;
                req_wdata[d] = ~wdata;
            end
            if (mem_write[d] === 1'b1) begin wr_cnt++; wr_i = i; end
            if (mem_address[d] !== addr || mem_wdata[d] !== wdata) hold_bad++;
            exp_ready = (i > lat);
            if (req_ready[d] !== exp_ready) ready_bad++;
            if (rsp_valid[d] === 1'b1) begin
                pulses++;
                if (rsp_i < 0) rsp_i = i;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s/rsp_extra: got response at +%0d want none", tag, i);
                end else begin
                    want = sb.pop_front();
                    if ({rsp_err[d], rsp_rdata[d]} !== {want.err, want.rdata}) begin
                        n_bad++;
                        $display("FAIL %s/rsp_data: got err=%b rdata=%h want err=%b rdata=%h",
                                 tag, rsp_err[d], rsp_rdata[d], want.err, want.rdata);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || rsp_i != lat) begin
            n_bad++;
            $display("FAIL %s/rsp_timing: got %0d pulses first at +%0d want 1 pulse at +%0d", tag, pulses, rsp_i, lat);
        end
        n_cmp++;
        if (wr_cnt != exp_wr || (exp_wr == 1 && wr_i != 0)) begin
            n_bad++;
            $display("FAIL %s/mem_write: got %0d strobes last at +%0d want %0d at +0", tag, wr_cnt, wr_i, exp_wr);
        end
        n_cmp++;
        if (hold_bad != 0) begin
            n_bad++;
            $display("FAIL %s/addr_hold: got %0d cycles off want 0 (addr %h data %h)", tag, hold_bad, addr, wdata);
        end
        n_cmp++;
        if (ready_bad != 0) begin
            n_bad++;
            $display("FAIL %s/req_ready: got %0d wrong cycles want 0", tag, ready_bad);
        end
        n_cmp++;
        if (rsp_rdata[d] !== last_rdata[d]) begin
            n_bad++;
            $display("FAIL %s/rdata_held: got %h want %h", tag, rsp_rdata[d], last_rdata[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d], mem_address[d], mem_write[d], mem_wdata[d]}
                !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00}) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got rdy=%b v=%b e=%b rd=%h a=%h w=%b wd=%h want rdy=1 rest 0", d,
                         req_ready[d], rsp_valid[d], rsp_err[d], rsp_rdata[d], mem_address[d], mem_write[d],
                         mem_wdata[d]);
            end
        end
    endtask

    task automatic test_store();
        run_req(0, 1'b1, 8'h80, 8'hA5, "store_80");
        run_req(0, 1'b1, 8'hC7, 8'h3E, "store_c7");
    endtask

    task automatic test_load_rw0();
        run_req(0, 1'b0, 8'h80, 8'h00, "load0_80");
        run_req(0, 1'b1, 8'hE1, 8'h99, "store_after_load");
        run_req(0, 1'b0, 8'hFF, 8'h00, "load0_ff");
        run_req(0, 1'b0, 8'hC7, 8'h00, "load0_c7");
    endtask

    task automatic test_load_rw3();
        run_req(1, 1'b0, 8'hDF, 8'h00, "load3_df_init");
        run_req(1, 1'b1, 8'hDF, 8'h6B, "store3_df");
        run_req(1, 1'b0, 8'hDF, 8'h00, "load3_df");
        run_req(1, 1'b0, 8'h00, 8'h00, "load3_00");
    endtask

    task automatic test_rom_protect();
        run_req(0, 1'b1, 8'h10, 8'h3C, "store_rom_10");
        run_req(0, 1'b0, 8'h10, 8'h00, "load_rom_10");
        run_req(0, 1'b1, 8'hE0, 8'h5E, "store_io_e0");
        run_req(0, 1'b0, 8'hE0, 8'h00, "load_io_e0");
        run_req(1, 1'b1, 8'h7F, 8'h12, "store3_rom_7f");
        run_req(1, 1'b0, 8'h7F, 8'h00, "load3_rom_7f");
    endtask

    task automatic test_back_to_back();
        bit         wr_l [3];
        logic [7:0] ad_l [3];
        logic [7:0] wd_l [3];
        int         acc [$];
        int         rsp [$];
        int         nxt, ready_bad;
        bit         took, exp_ready;
        exp_t       want;
        wr_l[0] = 1'b1; ad_l[0] = 8'h85; wd_l[0] = 8'hC1;
        wr_l[1] = 1'b0; ad_l[1] = 8'h85; wd_l[1] = 8'h00;
        wr_l[2] = 1'b1; ad_l[2] = 8'h86; wd_l[2] = 8'h77;
        nxt = 0; ready_bad = 0;
        drive_req(0, wr_l[0], ad_l[0], wd_l[0]);
        took = req_ready[0] && req_valid[0];
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (took) begin
                acc.push_back(n);
                nxt++;
                if (nxt < 3) drive_req(0, wr_l[nxt], ad_l[nxt], wd_l[nxt]);
                else req_valid[0] = 1'b0;
            end
            exp_ready = (n == 2 || n == 6 || n >= 9);
            if (req_ready[0] !== exp_ready) ready_bad++;
            if (rsp_valid[0] === 1'b1) begin
                rsp.push_back(n);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b/rsp_extra: got response at %0d want none", n);
                end else begin
                    want = sb.pop_front();
                    if ({rsp_err[0], rsp_rdata[0]} !== {want.err, want.rdata}) begin
                        n_bad++;
                        $display("FAIL b2b/rsp_data: got err=%b rdata=%h want err=%b rdata=%h",
                                 rsp_err[0], rsp_rdata[0], want.err, want.rdata);
                    end
                end
            end
            took = req_ready[0] && req_valid[0];
        end
        n_cmp++;
        if (acc.size() != 3 || acc[0] != 0 || acc[1] != 3 || acc[2] != 7) begin
            n_bad++;
            $display("FAIL b2b/accepts: got %0d accepts (%0d,%0d,%0d) want 3 (0,3,7)",
                     acc.size(), acc[0], acc[1], acc[2]);
        end
        n_cmp++;
        if (rsp.size() != 3 || rsp[0] != 1 || rsp[1] != 5 || rsp[2] != 8) begin
            n_bad++;
            $display("FAIL b2b/responses: got %0d pulses (%0d,%0d,%0d) want 3 (1,5,8)",
                     rsp.size(), rsp[0], rsp[1], rsp[2]);
        end
        n_cmp++;
        if (ready_bad != 0) begin
            n_bad++;
            $display("FAIL b2b/req_ready: got %0d wrong cycles want 0", ready_bad);
        end
    endtask

    task automatic test_reset_mid_issue();
        int pulses;
        n_cmp++;
        if (rsp_rdata[0] !== last_rdata[0]) begin
            n_bad++;
            $display("FAIL mid_reset/pre_rdata: got %h want %h", rsp_rdata[0], last_rdata[0]);
        end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h90; req_wdata[0] = 8'h3C;
        @(posedge clk);
        #2;
        n_cmp++;
        if (mem_write[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset/issue_strobe: got %b want 1", mem_write[0]);
        end
        reset_n = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        last_rdata[0] = 8'h00;
        last_rdata[1] = 8'h00;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL mid_reset/no_rsp: got %0d response cycles want 0", pulses);
        end
        run_req(0, 1'b0, 8'h90, 8'h00, "load_after_reset_90");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_val(8'(i));
            last_rdata[d] = 8'h00;
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = 8'h00;
            req_wdata[d]  = 8'h00;
        end
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_store();
        test_load_rw0();
        test_load_rw3();
        test_rom_protect();
        test_back_to_back();
        test_reset_mid_issue();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

CPU-side initiator for the 8-bit CPU's synchronous memory bus. Accepts one load/store request at a time from the core over a valid/ready handshake and sequences the bus strobes. For reads, it waits out the one-cycle synchronous read latency of the memory blocks (ROM 0–127, RW 128–223, I/O 224–255), captures the data and returns a one-cycle response. It sits between the CPU control unit and the address-decoded memory blocks, which share its `mem_address`/`mem_write`/`mem_wdata` outputs.

## Interface
Parameters:
- `READ_WAIT`, default 0: extra wait cycles between issue and capture on reads, range 0–7.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  the core presents a request.
- `req_ready`  out  1  the master can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  8  byte address.
- `req_wdata`  in  8  store data.
- `rsp_valid`  out  1  one-cycle pulse marking completion.
- `rsp_rdata`  out  8  load data; valid while `rsp_valid` is high and held until the next load completes.
- `rsp_err`  out  1  qualified by `rsp_valid`; 1 = rejected store.
- `mem_address`  out  8  bus address.
- `mem_write`  out  1  bus write strobe.
- `mem_wdata`  out  8  bus write data; drives the memories' `data_in`.
- `mem_rdata`  in  8  bus read data; the memories' `data_out`.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, register `req_addr`, `req_wdata`, `req_write` and the protection verdict, then go to ISSUE.
  - Request inputs are ignored in all other states.
- **ISSUE** (1 cycle)
  - `mem_address` = latched address.
  - `mem_wdata` = latched data.
  - `mem_write` = latched write AND NOT rejected.
  - Next state: a store goes to DONE; a load goes to WAIT if `READ_WAIT`>0, else CAPTURE.
- **WAIT**
  - Count down from `READ_WAIT` using a 3-bit counter.
  - Address held; `mem_write`=0.
  - Go to CAPTURE when the counter reaches 1.
- **CAPTURE**
  - Address held; `mem_write`=0.
  - `rsp_rdata` is loaded from `mem_rdata` on the exiting posedge.
  - Go to DONE.
- **DONE**
  - `rsp_valid`=1 and `rsp_err` = verdict; both are registered outputs.
  - `req_ready`=0.
  - Return to IDLE.
- `mem_write` is 1 only in ISSUE; it is never asserted in any other state.
- `mem_address` and `mem_wdata` hold their last values outside ISSUE, WAIT and CAPTURE.
- Stores do not modify `rsp_rdata`.
- Loads never error; all 256 addresses are readable.

## Timing
- Reset (async assert, any state): state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_address`=0, `mem_write`=0, `mem_wdata`=0.
- Reset asserted during ISSUE drops `mem_write` immediately without waiting for a clock edge. The in-flight request is lost and no response is produced.
- Deassert reset synchronously to `clk` externally; the first request can be accepted on the first posedge after deassertion.
- Accept at posedge k. ISSUE occupies cycle k..k+1; the memory acts at posedge k+1.
- Store: `rsp_valid` is high during cycle k+1..k+2.
- Load: `rsp_valid` is high during cycle k+2+`READ_WAIT`..k+3+`READ_WAIT`.
- Back-to-back throughput:
  - Store: one per 3 cycles.
  - Load: one per 4+`READ_WAIT` cycles.
- `req_valid` held high across DONE is accepted on the posedge leaving IDLE. There is no combinational path from `req_valid` to `req_ready`.

## Configuration
- `MEM_BUS_ROM_PROTECT_EN` defined:
  - A store with `req_addr` < 128 is rejected: ISSUE drives `mem_write`=0 and DONE reports `rsp_err`=1.
  - Timing is unchanged.
- Not defined:
  - All stores are issued with `mem_write`=1.
  - `rsp_err` is tied 0.

## Test plan
- **Reset:** pulse `reset_n` low mid-ISSUE of a store to 0x90 → `mem_write` falls without a clock edge, no `rsp_valid`, all outputs 0, `req_ready`=1.
- **Store:** store 0xA5 to 0x80 accepted at posedge k → `mem_write`=1, `mem_address`=0x80, `mem_wdata`=0xA5 for exactly cycle k..k+1; `rsp_valid` pulse at k+1..k+2 with `rsp_err`=0.
- **Load, `READ_WAIT`=0:** load from 0x80 (model returns 0xA5) → `rsp_valid` at k+2..k+3 with `rsp_rdata`=0xA5; `rsp_rdata` still 0xA5 after a later store.
- **Load, `READ_WAIT`=3:** load from 0xDF → `rsp_valid` at k+5..k+6 with `rsp_rdata` = model value; address held at 0xDF in every cycle from ISSUE through CAPTURE.
- **ROM protect:** store 0x3C to 0x10:
  - With `MEM_BUS_ROM_PROTECT_EN`: no `mem_write` pulse, `rsp_err`=1.
  - Without: `mem_write` pulse, `rsp_err`=0.
  - Store to 0xE0: never an error in either build.
- **Back-to-back:** `req_valid` held high with store, load, store → accepts at k, k+3, k+7; exactly three `rsp_valid` pulses; `req_ready` low outside IDLE.
